vxe_txnreq_split: RTL and testbench
===================================

# vxe_txnreq_split

Parametrised, registered successor to the combinational request coder. Accepts one full memory request per cycle on a valid/ready interface. Encodes it into separate address-vector and data-vector channels, each buffered by its own FIFO with independent valid/ready. Sits between a VxE request producer (VPU/CU memory port) and the memory interconnect; reads occupy only the address channel.

## Interface
Parameters:
- TXNID_W, 6, transaction ID width
- ADDR_W, 37, address width (64-bit word address)
- DATA_W, 64, data width; multiple of 8; BEN_W = DATA_W/8
- TXN_DEPTH, 2, address FIFO depth; power of two, ≥2
- DAT_DEPTH, 2, data FIFO depth; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_txnid  in  TXNID_W  transaction ID
- i_rnw  in  1  1 = read, 0 = write
- i_addr  in  ADDR_W  address
- i_data  in  DATA_W  write data; ignored for reads
- i_ben  in  BEN_W  byte enables; ignored for reads
- o_txn_valid  out  1  address-channel vector valid
- i_txn_ready  in  1  address-channel consumer ready
- o_req_vec_txn  out  TXNID_W+1+ADDR_W  {txnid, rnw, addr}; addr at LSBs
- o_dat_valid  out  1  data-channel vector valid
- i_dat_ready  in  1  data-channel consumer ready
- o_req_vec_dat  out  DATA_W+BEN_W  {data, ben}; ben at LSBs
- o_idle  out  1  both FIFOs empty

## Operation
- Encode: txn vector = {i_txnid, i_rnw, i_addr}; dat vector = {i_data, i_ben}. Bit layout is identical to the existing vxe_txnreq_coder at default parameters.
- o_ready = !txn_full & (i_rnw | !dat_full). Combinational from registered FIFO counts only; a same-cycle pop does not raise o_ready.
- Accept on a read: push txn vector only.
- Accept on a write: push txn vector and dat vector in the same cycle. A write is never split across cycles.
- Each FIFO uses a circular buffer with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap DEPTH-1 → 0.
- Pop: txn FIFO on o_txn_valid & i_txn_ready; dat FIFO on o_dat_valid & i_dat_ready. The two channels drain independently. Data entries stay in write-request order.
- o_*_valid = FIFO count != 0; o_req_vec_* = head entry when valid, all-zero when not valid.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. Legal at any non-full count. When full, push cannot occur because o_ready = 0.
- o_idle = txn count == 0 & dat count == 0.
- Reset: pointers and counts cleared. FIFO storage is not reset. Reset mid-operation discards all buffered entries with no partial output.

## Timing
- Reset values: o_ready = 1, o_txn_valid = 0, o_dat_valid = 0, both vectors = 0, o_idle = 1.
- Latency: request accepted at edge N → vectors valid after edge N (visible in cycle N+1). No combinational input-to-output path except i_rnw → o_ready.
- Throughput: one request per cycle sustained while consumers are always ready.
- Valid/ready rules: o_*_valid never drops without a handshake. The vector is held stable while valid & !ready.
- Full: after DEPTH unpopped pushes, o_ready = 0 for writes. Reads are blocked only by a full txn FIFO.
- Empty: o_*_valid = 0 in the cycle following the last pop.

## Test plan
- Write txnid 3f, addr 03_0303_0303, data fefe_fafa_dada_dede, ben 33, consumers ready → next cycle o_req_vec_txn = 44'hFC3_0303_0303 and o_req_vec_dat = 72'hfefefafadadadede33, each valid for exactly one cycle; o_idle returns to 1.
- Read txnid 2a, addr 1f_1313_1313 → o_req_vec_txn = 44'hABF_1313_1313; o_dat_valid stays 0 throughout.
- i_dat_ready = 0, i_txn_ready = 1, issue 3 writes (DEPTH = 2) → third write stalls (o_ready = 0); a read issued while stalled is accepted. Raise i_dat_ready → data pops in write order.
- i_txn_ready = 0 for 3 back-to-back reads → first two accepted, third stalls. Then toggle i_txn_ready every other cycle → vector held stable while stalled; count and pointer wrap verified over 8 transactions.
- Continuous writes with both readies high for 16 cycles → 16 txn and 16 dat vectors, one per cycle, no bubbles.
- Assert rst with 2 entries buffered in each FIFO → next cycle both valids = 0, vectors = 0, o_ready = 1, o_idle = 1.

Source files
------------

// File: rtl/vxe_txnreq_split.sv
// Registered request splitter: one memory request per cycle in, separate
// address-vector and data-vector channels out, each behind its own FIFO.

module vxe_txnreq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign o_valid = (count_q != '0);
    assign o_full  = (count_q == DEPTH_C);
    assign pop     = o_valid & pop_ready;
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module vxe_txnreq_split #(
    parameter int TXNID_W   = 6,
    parameter int ADDR_W    = 37,
    parameter int DATA_W    = 64,
    parameter int TXN_DEPTH = 2,
    parameter int DAT_DEPTH = 2,
    parameter int BEN_W     = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [TXNID_W-1:0]          i_txnid,
    input  logic                        i_rnw,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [DATA_W-1:0]           i_data,
    input  logic [BEN_W-1:0]            i_ben,
    output logic                        o_txn_valid,
    input  logic                        i_txn_ready,
    output logic [TXNID_W+ADDR_W:0]     o_req_vec_txn,
    output logic                        o_dat_valid,
    input  logic                        i_dat_ready,
    output logic [DATA_W+BEN_W-1:0]     o_req_vec_dat,
    output logic                        o_idle
);
    localparam int TXN_W = TXNID_W + 1 + ADDR_W;
    localparam int DAT_W = DATA_W + BEN_W;

    logic             txn_full;
    logic             dat_full;
    logic             accept;
    logic             txn_push;
    logic             dat_push;
    logic [TXN_W-1:0] txn_vec;
    logic [DAT_W-1:0] dat_vec;

    // Readiness looks only at registered counts; a pop in this cycle does not help.
    assign o_ready  = !txn_full & (i_rnw | !dat_full);
    assign accept   = i_valid & o_ready;
    assign txn_push = accept;
    assign dat_push = accept & !i_rnw;
    assign txn_vec  = {i_txnid, i_rnw, i_addr};
    assign dat_vec  = {i_data, i_ben};
    assign o_idle   = !o_txn_valid & !o_dat_valid;

    vxe_txnreq_fifo #(
        .W     (TXN_W),
        .DEPTH (TXN_DEPTH)
    ) u_txn_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (txn_push),
        .push_data (txn_vec),
        .pop_ready (i_txn_ready),
        .o_valid   (o_txn_valid),
        .o_data    (o_req_vec_txn),
        .o_full    (txn_full)
    );

    vxe_txnreq_fifo #(
        .W     (DAT_W),
        .DEPTH (DAT_DEPTH)
    ) u_dat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dat_push),
        .push_data (dat_vec),
        .pop_ready (i_dat_ready),
        .o_valid   (o_dat_valid),
        .o_data    (o_req_vec_dat),
        .o_full    (dat_full)
    );
endmodule

// File: tb/tb_vxe_txnreq_split.sv
// Scoreboard bench for vxe_txnreq_split: stimulus queues expected vectors,
// a negedge monitor compares and retires them on each handshake.

module tb_vxe_txnreq_split;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [5:0]   i_txnid;
    logic         i_rnw;
    logic [36:0]  i_addr;
    logic [63:0]  i_data;
    logic [7:0]   i_ben;
    logic         o_txn_valid;
    logic         i_txn_ready;
    logic [43:0]  o_req_vec_txn;
    logic         o_dat_valid;
    logic         i_dat_ready;
    logic [71:0]  o_req_vec_dat;
    logic         o_idle;

    int n_checks = 0;
    int n_fail   = 0;
    int txn_pops = 0;
    int dat_pops = 0;
    logic [43:0] txn_q[$];
    logic [71:0] dat_q[$];

    vxe_txnreq_split dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_txnid       (i_txnid),
        .i_rnw         (i_rnw),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .i_ben         (i_ben),
        .o_txn_valid   (o_txn_valid),
        .i_txn_ready   (i_txn_ready),
        .o_req_vec_txn (o_req_vec_txn),
        .o_dat_valid   (o_dat_valid),
        .i_dat_ready   (i_dat_ready),
        .o_req_vec_dat (o_req_vec_dat),
        .o_idle        (o_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic rnw, input logic [5:0] id, input logic [36:0] a,
                            input logic [63:0] d, input logic [7:0] b);
        txn_q.push_back({id, rnw, a});
        if (!rnw) dat_q.push_back({d, b});
    endtask

    task automatic drive(input logic rnw, input logic [5:0] id, input logic [36:0] a,
                         input logic [63:0] d, input logic [7:0] b);
        i_valid = 1'b1;
        i_rnw   = rnw;
        i_txnid = id;
        i_addr  = a;
        i_data  = d;
        i_ben   = b;
    endtask

    // Single attempt with a hand-predicted o_ready.
    task automatic issue(input logic rnw, input logic [5:0] id, input logic [36:0] a,
                         input logic [63:0] d, input logic [7:0] b,
                         input logic exp_rdy, input string nm);
        drive(rnw, id, a, d, b);
        @(negedge clk);
        chk(nm, o_ready, exp_rdy);
        if (o_ready) push_exp(rnw, id, a, d, b);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Retry until accepted, bounded.
    task automatic send(input logic rnw, input logic [5:0] id, input logic [36:0] a,
                        input logic [63:0] d, input logic [7:0] b, input string nm);
        bit ok = 1'b0;
        drive(rnw, id, a, d, b);
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (o_ready) begin
                push_exp(rnw, id, a, d, b);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: request not accepted within 64 cycles", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (o_idle) seen = 1'b1;
        end
        chk({nm, "_idle"}, o_idle, 1'b1);
        chk({nm, "_txn_left"}, txn_q.size(), 0);
        chk({nm, "_dat_left"}, dat_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_txn_valid) begin
                if (txn_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL txn_unexpected: got %0h expected no valid", o_req_vec_txn);
                end else begin
                    chk("txn_vec", o_req_vec_txn, txn_q[0]);
                    if (i_txn_ready) begin
                        void'(txn_q.pop_front());
                        txn_pops++;
                    end
                end
            end else begin
                chk("txn_zero", o_req_vec_txn, '0);
            end
            if (o_dat_valid) begin
                if (dat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dat_unexpected: got %0h expected no valid", o_req_vec_dat);
                end else begin
                    chk("dat_vec", o_req_vec_dat, dat_q[0]);
                    if (i_dat_ready) begin
                        void'(dat_q.pop_front());
                        dat_pops++;
                    end
                end
            end else begin
                chk("dat_zero", o_req_vec_dat, '0);
            end
        end
    end

    initial begin
        int p0;
        int d0;
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_txnid     = '0;
        i_rnw       = 1'b0;
        i_addr      = '0;
        i_data      = '0;
        i_ben       = '0;
        i_txn_ready = 1'b1;
        i_dat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_txn_valid", o_txn_valid, 1'b0);
        chk("rst_dat_valid", o_dat_valid, 1'b0);
        chk("rst_idle", o_idle, 1'b1);
        @(posedge clk);
        #1;

        // single write, both consumers ready
        issue(1'b0, 6'h3f, 37'h03_0303_0303, 64'hfefe_fafa_dada_dede, 8'h33, 1'b1, "w1_ready");
        @(negedge clk);
        chk("w1_txn_const", o_req_vec_txn, 44'hFC3_0303_0303);
        chk("w1_dat_const", o_req_vec_dat, 72'hfefefafadadadede33);
        chk("w1_txn_valid", o_txn_valid, 1'b1);
        chk("w1_dat_valid", o_dat_valid, 1'b1);
        chk("w1_busy", o_idle, 1'b0);
        @(negedge clk);
        chk("w1_txn_gone", o_txn_valid, 1'b0);
        chk("w1_dat_gone", o_dat_valid, 1'b0);
        chk("w1_idle", o_idle, 1'b1);
        @(posedge clk);
        #1;

        // single read: address channel only
        issue(1'b1, 6'h2a, 37'h1f_1313_1313, 64'h1111_2222_3333_4444, 8'hff, 1'b1, "r1_ready");
        @(negedge clk);
        chk("r1_txn_const", o_req_vec_txn, 44'hABF_1313_1313);
        chk("r1_txn_valid", o_txn_valid, 1'b1);
        chk("r1_dat_valid", o_dat_valid, 1'b0);
        @(negedge clk);
        chk("r1_txn_gone", o_txn_valid, 1'b0);
        chk("r1_dat_still0", o_dat_valid, 1'b0);
        @(posedge clk);
        #1;

        // data channel stalled: third write blocks, read still passes
        i_dat_ready = 1'b0;
        issue(1'b0, 6'h01, 37'h00_0000_0100, 64'h0101_0101_0101_0101, 8'h01, 1'b1, "s_w1");
        issue(1'b0, 6'h02, 37'h00_0000_0200, 64'h0202_0202_0202_0202, 8'h03, 1'b1, "s_w2");
        issue(1'b0, 6'h03, 37'h00_0000_0300, 64'h0303_0303_0303_0303, 8'h07, 1'b0, "s_w3_stall");
        issue(1'b1, 6'h04, 37'h00_0000_0400, 64'h0, 8'h0, 1'b1, "s_rd_pass");
        @(negedge clk);
        chk("s_dat_held", o_dat_valid, 1'b1);
        @(posedge clk);
        #1;
        i_dat_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 6'h03, 37'h00_0000_0300, 64'h0303_0303_0303_0303, 8'h07, 1'b1, "s_w3_retry");
        wait_idle("stall");

        // address channel stalled, then throttled every other cycle
        i_txn_ready = 1'b0;
        p0 = txn_pops;
        issue(1'b1, 6'h10, 37'h10_0000_0010, 64'h0, 8'h0, 1'b1, "t_r0");
        issue(1'b1, 6'h11, 37'h11_0000_0011, 64'h0, 8'h0, 1'b1, "t_r1");
        issue(1'b1, 6'h12, 37'h12_0000_0012, 64'h0, 8'h0, 1'b0, "t_r2_stall");
        fork
            begin
                repeat (40) begin
                    @(posedge clk);
                    #2;
                    i_txn_ready = ~i_txn_ready;
                end
            end
            begin
                for (int k = 0; k < 6; k++)
                    send(1'b1, 6'(6'h12 + k), 37'(37'h12_0000_0000 + k * 37'h1_0101), 64'h0, 8'h0, "t_send");
            end
        join
        i_txn_ready = 1'b1;
        wait_idle("throttle");
        chk("t_pop_count", txn_pops - p0, 8);

        // back-to-back writes, both consumers always ready
        p0 = txn_pops;
        d0 = dat_pops;
        for (int k = 0; k < 16; k++)
            issue(1'b0, 6'(k), 37'(k * 37'h0_1000_0001), {8{8'(k * 17 + 5)}}, 8'(8'h80 >> (k % 8)),
                  1'b1, "bb_ready");
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bb_txn_pops", txn_pops - p0, 16);
        chk("bb_dat_pops", dat_pops - d0, 16);
        chk("bb_idle", o_idle, 1'b1);

        // reset with both FIFOs full
        i_txn_ready = 1'b0;
        i_dat_ready = 1'b0;
        issue(1'b0, 6'h21, 37'h00_dead_beef, 64'haaaa_bbbb_cccc_dddd, 8'h5a, 1'b1, "r_w1");
        issue(1'b0, 6'h22, 37'h01_cafe_f00d, 64'h1234_5678_9abc_def0, 8'ha5, 1'b1, "r_w2");
        issue(1'b1, 6'h23, 37'h00_0000_0001, 64'h0, 8'h0, 1'b0, "r_full");
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        txn_q.delete();
        dat_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_txn_valid", o_txn_valid, 1'b0);
        chk("rr_dat_valid", o_dat_valid, 1'b0);
        chk("rr_txn_vec", o_req_vec_txn, '0);
        chk("rr_dat_vec", o_req_vec_dat, '0);
        chk("rr_ready", o_ready, 1'b1);
        chk("rr_idle", o_idle, 1'b1);
        @(posedge clk);
        #1;
        i_txn_ready = 1'b1;
        i_dat_ready = 1'b1;
        issue(1'b0, 6'h30, 37'h00_0000_0030, 64'h3030_3030_3030_3030, 8'hf0, 1'b1, "post_rst");
        wait_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
